// File: rtl/prf_wb_pkg.sv
// prf_wb_pkg: shared types and helpers for the PRF writeback arbiter.
//   NREGS/XLEN/PREG_W : physical register file geometry
//   wb_req_t          : one completed result {paddr, data}
//   rr_pick()         : round-robin search returning {any, one-hot grant, index}
package prf_wb_pkg;

    localparam int NREGS  = 128;
    localparam int XLEN   = 32;
    localparam int PREG_W = $clog2(NREGS);

    // rr_pick works on a fixed-width request vector; callers zero-extend.
    localparam int NSRC_MAX  = 16;
    localparam int IDX_MAX_W = 4;

    typedef struct packed {
        logic [PREG_W-1:0] paddr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef struct packed {
        logic                 any;
        logic [NSRC_MAX-1:0]  gnt;
        logic [IDX_MAX_W-1:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, wrapping modulo n (n <= NSRC_MAX).
    function automatic rr_pick_t rr_pick(input logic [NSRC_MAX-1:0] req,
                                         input int unsigned ptr,
                                         input int unsigned n);
        rr_pick_t    r;
        int unsigned k;
        r = '0;
        for (int unsigned i = 0; i < NSRC_MAX; i++) begin
            k = ptr + i;
            if (k >= n) k = k - n;
            if (i < n && !r.any && req[k[IDX_MAX_W-1:0]]) begin
                r.any                    = 1'b1;
                r.gnt[k[IDX_MAX_W-1:0]]  = 1'b1;
                r.idx                    = k[IDX_MAX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prf_wb_fifo.sv
// prf_wb_fifo: single-source result buffer of wb_req_t entries.
//   clk_i, rst_i (async, active-high), flush_i (sync clear)
//   push_i/din_i : enqueue (ignored when full or flushing)
//   pop_i        : dequeue head (ignored when empty)
//   head_o       : current head entry
//   empty_o      : no entries held
//   not_full_o   : registered, so upstream ready never sees same-cycle pops
module prf_wb_fifo
    import prf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    flush_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  wb_req_t din_i,
    output wb_req_t head_o,
    output logic    empty_o,
    output logic    not_full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_not_full;
    logic            w_push, w_pop;

    assign w_push    = push_i & r_not_full;
    assign w_pop     = pop_i & (r_cnt != '0);
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_not_full <= 1'b1;
        end else if (flush_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_not_full <= 1'b1;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_cnt      <= w_cnt_nxt;
            r_not_full <= (w_cnt_nxt < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wptr] <= din_i;
    end

    assign head_o     = r_mem[r_rptr];
    assign empty_o    = (r_cnt == '0);
    assign not_full_o = r_not_full;

endmodule

// File: rtl/prf_wb_arbiter.sv
// prf_wb_arbiter: round-robin writeback arbiter for the PRF single write port.
// Build option: WB_ARB_BUF_EN
//   defined   -> per-source FIFOs (prf_wb_fifo), registered ready
//   undefined -> arbitration directly on src_valid_i, ready = combinational grant
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync drop of pending results)
//   src_valid_i/src_paddr_i/src_data_i/src_ready_o : per-source result handshakes
//   wb_en_o/wb_addr_o/wb_data_o/wb_src_o           : registered write to the PRF
module prf_wb_arbiter
    import prf_wb_pkg::*;
#(
    parameter int NSRC      = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NSRC-1:0]              src_valid_i,
    input  logic [NSRC-1:0][PREG_W-1:0]  src_paddr_i,
    input  logic [NSRC-1:0][XLEN-1:0]    src_data_i,
    output logic [NSRC-1:0]              src_ready_o,
    output logic                         wb_en_o,
    output logic [PREG_W-1:0]            wb_addr_o,
    output logic [XLEN-1:0]              wb_data_o,
    output logic [$clog2(NSRC)-1:0]      wb_src_o
);

    localparam int SRC_W = $clog2(NSRC);

    logic [NSRC-1:0]   w_req, w_gnt;
    wb_req_t           w_head [NSRC];
    wb_req_t           w_sel;
    rr_pick_t          w_pick, w_unused_pick;
    logic [SRC_W-1:0]  w_idx, w_rr_nxt;

    logic              r_wb_en;
    logic [PREG_W-1:0] r_wb_addr;
    logic [XLEN-1:0]   r_wb_data;
    logic [SRC_W-1:0]  r_wb_src;
    logic [SRC_W-1:0]  r_rr;

`ifdef WB_ARB_BUF_EN
    logic [NSRC-1:0] w_not_full, w_empty;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        prf_wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .push_i     (src_valid_i[k] & w_not_full[k]),
            .pop_i      (w_gnt[k]),
            .din_i      ({src_paddr_i[k], src_data_i[k]}),
            .head_o     (w_head[k]),
            .empty_o    (w_empty[k]),
            .not_full_o (w_not_full[k])
        );
    end

    assign w_req       = ~w_empty;
    assign src_ready_o = w_not_full;
`else
    logic w_unused_depth;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        assign w_head[k] = {src_paddr_i[k], src_data_i[k]};
    end

    assign w_req          = src_valid_i;
    // Nothing is accepted during flush, so no result is silently lost.
    assign src_ready_o    = flush_i ? '0 : w_gnt;
    assign w_unused_depth = (BUF_DEPTH != 0);
`endif

    assign w_pick        = rr_pick(NSRC_MAX'(w_req), 32'(r_rr), NSRC);
    assign w_unused_pick = w_pick;
    assign w_gnt         = w_pick.gnt[NSRC-1:0];
    assign w_idx         = w_pick.idx[SRC_W-1:0];
    assign w_sel         = w_head[w_idx];
    assign w_rr_nxt      = (w_idx == SRC_W'(NSRC - 1)) ? '0 : w_idx + SRC_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_src  <= '0;
            r_rr      <= '0;
        end else if (flush_i) begin
            r_wb_en <= 1'b0;
            r_rr    <= '0;
        end else if (w_pick.any) begin
            r_rr <= w_rr_nxt;
            // p0 results are consumed but never written.
            if (w_sel.paddr != '0) begin
                r_wb_en   <= 1'b1;
                r_wb_addr <= w_sel.paddr;
                r_wb_data <= w_sel.data;
                r_wb_src  <= w_idx;
            end else begin
                r_wb_en <= 1'b0;
            end
        end else begin
            r_wb_en <= 1'b0;
        end
    end

    assign wb_en_o   = r_wb_en;
    assign wb_addr_o = r_wb_addr;
    assign wb_data_o = r_wb_data;
    assign wb_src_o  = r_wb_src;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
module tb_prf_wb_arbiter;

    localparam int N = 4;
    localparam int D = 2;
`ifdef WB_ARB_BUF_EN
    localparam int LAT = 2;
    localparam logic [N-1:0] RST_RDY = '1;
`else
    localparam int LAT = 1;
    localparam logic [N-1:0] RST_RDY = '0;
`endif

    logic                clk = 1'b0;
    logic                rst, flush;
    logic [N-1:0]        valid, ready;
    logic [N-1:0][6:0]   paddr;
    logic [N-1:0][31:0]  data;
    logic                wb_en;
    logic [6:0]          wb_addr;
    logic [31:0]         wb_data;
    logic [1:0]          wb_src;

    always #5 clk = ~clk;

    prf_wb_arbiter #(.NSRC(N), .BUF_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .src_valid_i(valid), .src_paddr_i(paddr), .src_data_i(data),
        .src_ready_o(ready),
        .wb_en_o(wb_en), .wb_addr_o(wb_addr), .wb_data_o(wb_data), .wb_src_o(wb_src)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: queues per source, a round-robin pointer, expected outputs.
    typedef struct packed { logic [6:0] a; logic [31:0] d; } ent_t;
    ent_t        mq [N][$];
    int          m_rr;
    logic        m_en;
    logic [6:0]  m_addr;
    logic [31:0] m_data;
    int          m_src;

    // Source drivers: pending item per source.
    logic [N-1:0] sv;
    logic [6:0]   sp [N];
    logic [31:0]  sd [N];
    logic [N-1:0] last_hs;

    task automatic model_reset();
        for (int k = 0; k < N; k++) mq[k].delete();
        m_rr = 0; m_en = 0; m_addr = '0; m_data = '0; m_src = 0;
        sv = '0;
    endtask

    task automatic refill(input int p, input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[k] && !sv[k] && int'($urandom_range(99)) < p) begin
                sv[k] = 1'b1;
                sp[k] = ($urandom_range(7) == 0) ? 7'd0 : 7'($urandom);
                sd[k] = $urandom;
            end
        end
    endtask

    // One clock: drive at negedge, check ready, advance model, check outputs after posedge.
    task automatic step(input logic fl);
        logic [N-1:0] rdy;
        int           win;
        ent_t         e;
        flush = fl;
        for (int k = 0; k < N; k++) begin
            valid[k] = sv[k]; paddr[k] = sp[k]; data[k] = sd[k];
        end
        #1;
        win = -1;
        rdy = '0;
`ifdef WB_ARB_BUF_EN
        for (int k = 0; k < N; k++) rdy[k] = (mq[k].size() < D);
        if (!fl)
            for (int i = 0; i < N; i++) begin
                int k = (m_rr + i) % N;
                if (win < 0 && mq[k].size() != 0) win = k;
            end
`else
        if (!fl)
            for (int i = 0; i < N; i++) begin
                int k = (m_rr + i) % N;
                if (win < 0 && sv[k]) win = k;
            end
        if (win >= 0) rdy[win] = 1'b1;
`endif
        chk("ready", 64'(ready), 64'(rdy));
        last_hs = sv & rdy;
        if (fl) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            m_rr = 0; m_en = 0;
        end else begin
            if (win >= 0) begin
`ifdef WB_ARB_BUF_EN
                e = mq[win].pop_front();
`else
                e = '{a: sp[win], d: sd[win]};
`endif
                m_rr = (win + 1) % N;
                if (e.a != 0) begin
                    m_en = 1; m_addr = e.a; m_data = e.d; m_src = win;
                end else m_en = 0;
            end else m_en = 0;
`ifdef WB_ARB_BUF_EN
            for (int k = 0; k < N; k++)
                if (last_hs[k]) mq[k].push_back('{a: sp[k], d: sd[k]});
`endif
        end
        @(posedge clk); #1;
        chk("wb_en",   64'(wb_en),   64'(m_en));
        chk("wb_addr", 64'(wb_addr), 64'(m_addr));
        chk("wb_data", 64'(wb_data), 64'(m_data));
        chk("wb_src",  64'(wb_src),  64'(m_src[1:0]));
        sv = sv & ~last_hs;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [6:0]  b_a [3];
    logic [31:0] b_d [3];
    logic [6:0]  g_a [$];
    logic [31:0] g_d [$];
    int          prev, nb;
    bit          seen;

    task automatic step_rec(input logic fl);
        step(fl);
        if (wb_en && wb_src == 2'd0) begin g_a.push_back(wb_addr); g_d.push_back(wb_data); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = '0; paddr = '0; data = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_en",   64'(wb_en),   64'd0);
        chk("rst_addr", 64'(wb_addr), 64'd0);
        chk("rst_data", 64'(wb_data), 64'd0);
        chk("rst_src",  64'(wb_src),  64'd0);
        chk("rst_rdy",  64'(ready),   64'(RST_RDY));
        rst = 1'b0;

        // Single result from source 2: one write at the minimum latency only.
        sv[2] = 1'b1; sp[2] = 7'd5; sd[2] = 32'hDEADBEEF;
        for (int t = 1; t <= 3; t++) begin
            step(1'b0);
            chk("single_en", 64'(wb_en), 64'(t == LAT));
            if (t == LAT) begin
                chk("single_addr", 64'(wb_addr), 64'd5);
                chk("single_data", 64'(wb_data), 64'hDEADBEEF);
                chk("single_src",  64'(wb_src),  64'd2);
            end
        end

        // Fairness: all sources pending from reset.
        reset_dut();
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            refill(100, '1);
            for (int k = 0; k < N; k++) if (sv[k] && sp[k] == 0) sp[k] = 7'd1;
            step(1'b0);
            if (i >= 3) chk("fair_en", 64'(wb_en), 64'd1);
            if (i >= 4) chk("fair_src", 64'(wb_src), 64'((prev + 1) % N));
            prev = int'(wb_src);
        end
        for (int i = 0; i < 10; i++) step(1'b0);

        // p0 result is consumed silently and still advances the pointer.
        sv[1] = 1'b1; sp[1] = 7'd0; sd[1] = 32'h1234;
        step(1'b0);
        chk("p0_hs", 64'(last_hs[1]), 64'd1);
        sv[0] = 1'b1; sp[0] = 7'd9;  sd[0] = $urandom;
        sv[2] = 1'b1; sp[2] = 7'd11; sd[2] = $urandom;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step(1'b0);
            if (wb_en) begin seen = 1; chk("p0_next_src", 64'(wb_src), 64'd2); end
        end
        if (!seen) chk("p0_timeout", 64'd0, 64'd1);
        for (int i = 0; i < 6; i++) step(1'b0);

        // Backpressure: source 0 sends 3 results against saturated neighbours.
        b_a[0] = 7'd3; b_a[1] = 7'd4; b_a[2] = 7'd6;
        for (int j = 0; j < 3; j++) b_d[j] = $urandom;
        nb = 0;
        for (int i = 0; i < 30; i++) begin
            if (!sv[0] && nb < 3) begin sv[0] = 1'b1; sp[0] = b_a[nb]; sd[0] = b_d[nb]; nb++; end
            refill(100, 4'b1110);
            step_rec(1'b0);
        end
        for (int i = 0; i < 12; i++) step_rec(1'b0);
        chk("bp_count", 64'(g_a.size()), 64'd3);
        for (int j = 0; j < 3 && j < g_a.size(); j++) begin
            chk("bp_addr", 64'(g_a[j]), 64'(b_a[j]));
            chk("bp_data", 64'(g_d[j]), 64'(b_d[j]));
        end

        // Flush while source 3 has results queued behind busy neighbours.
        for (int j = 0; j < 2; j++) begin
            if (!sv[3]) begin sv[3] = 1'b1; sp[3] = 7'd20 + 7'(j); sd[3] = $urandom; end
            refill(100, 4'b0111);
            step(1'b0);
        end
        step(1'b1);
        step(1'b0);
        for (int i = 0; i < 12; i++) step(1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            refill(int'($urandom_range(100)), '1);
            step($urandom_range(99) < 4);
        end

        // Asynchronous reset between edges while writing.
        for (int i = 0; i < 6; i++) begin
            refill(100, '1);
            for (int k = 0; k < N; k++) if (sv[k] && sp[k] == 0) sp[k] = 7'd2;
            step(1'b0);
        end
        rst = 1'b1;
        #1;
        chk("arst_en",   64'(wb_en),   64'd0);
        chk("arst_addr", 64'(wb_addr), 64'd0);
        chk("arst_data", 64'(wb_data), 64'd0);
        chk("arst_src",  64'(wb_src),  64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prf_wb_arbiter.md
# prf_wb_arbiter

Writeback arbiter feeding the physical register file's single write port. It collects completed results (physical destination + data) from NSRC functional units over valid/ready handshakes, buffers them per source, and selects one per cycle with round-robin priority. It drives the registered wb_en/wb_addr/wb_data triple the register file and wakeup logic consume.

## Interface
- NSRC, 4: number of result sources (≥2)
- NREGS, 128: physical registers; PREG_W = $clog2(NREGS)
- XLEN, 32: data width
- BUF_DEPTH, 2: per-source buffer entries (≥2, power of 2); used only when buffering is compiled in

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous flush of all buffered, not-yet-written results
- src_valid_i  in  NSRC  per-source result valid
- src_paddr_i  in  NSRC×PREG_W  per-source physical destination
- src_data_i  in  NSRC×XLEN  per-source result data
- src_ready_o  out  NSRC  per-source ready
- wb_en_o  out  1  register-file write enable (registered)
- wb_addr_o  out  PREG_W  write address (registered)
- wb_data_o  out  XLEN  write data (registered)
- wb_src_o  out  $clog2(NSRC)  index of the source that produced the current write (registered)

## Operation
- Transfer on a source: src_valid_i[k] & src_ready_o[k] in the same cycle. Source holds paddr/data stable while valid is high and ready is low.
- Per-source FIFO (buffered build): push on transfer, pop when the head is granted. src_ready_o[k] = (count[k] < BUF_DEPTH). It depends only on registered state, never on the same-cycle grant.
- Arbitration: candidates = non-empty FIFO heads. Round-robin pointer rr_q: the search starts at rr_q. The first candidate found at or after rr_q (with wrap modulo NSRC) wins. After a grant to k, rr_q <= (k+1) mod NSRC. With no grant, rr_q holds.
- A granted entry with paddr == 0 is popped and discarded: wb_en_o = 0 that cycle. rr_q still advances. This matches the register file ignoring p0.
- Output register: on a grant with paddr ≠ 0, next cycle wb_en_o = 1, wb_addr_o/wb_data_o = head contents, wb_src_o = k. Otherwise wb_en_o = 0 and addr/data/src hold their last values.
- Full and empty: a full FIFO deasserts ready; a push to a full FIFO cannot occur. A pop and a push on the same FIFO in one cycle leave count unchanged.
- flush_i: all FIFO counts and pointers go to 0, and wb_en_o goes to 0 next cycle. Transfers presented during the flush cycle are dropped. rr_q resets to 0.
- Reset values: wb_en_o = 0, wb_addr_o = 0, wb_data_o = 0, wb_src_o = 0, rr_q = 0, all counts = 0. src_ready_o is all-ones after reset (buffered build). Reset asserted mid-operation discards every buffered result.

## Timing
- Buffered: a transfer in cycle t makes the entry visible at the FIFO head in t+1. If it is granted in t+1, wb_en_o is high in t+2. Minimum latency is 2 cycles.
- Unbuffered: arbitration runs directly on src_valid_i. A win in cycle t gives wb_en_o in t+1. Minimum latency is 1 cycle.
- Throughput: at most one register-file write per cycle; sustained 1/cycle while any source is non-empty.
- Fairness: with all NSRC sources continuously pending, each source is granted exactly once per NSRC cycles.

## Configuration
- WB_ARB_BUF_EN defined: per-source FIFOs of BUF_DEPTH entries and registered ready, as described above.
- WB_ARB_BUF_EN undefined:
  - No FIFOs.
  - src_ready_o[k] = combinational grant of k over raw src_valid_i. This is a valid-to-ready combinational path.
  - BUF_DEPTH is ignored.
  - flush_i only clears the output register and rr_q.

## Structure
- Package prf_wb_pkg:
  - PREG_W and XLEN localparams derived from the shared NREGS/XLEN
  - typedef wb_req_t packed struct {paddr, data}
  - function rr_pick(req vector, ptr) returning a one-hot grant and an index
- Sub-module prf_wb_fifo:
  - single-source FIFO of wb_req_t
  - push/pop/flush, count, registered not_full, head output
  - instantiated NSRC times under WB_ARB_BUF_EN

## Test plan
- Single result: source 2 sends paddr=5, data=0xDEADBEEF at t=0 (buffered). Expect wb_en_o=1, wb_addr_o=5, wb_data_o=0xDEADBEEF, wb_src_o=2 at t=2 only.
- Fairness: all 4 sources valid continuously from reset. Expect wb_src_o sequence 0,1,2,3,0,1… with wb_en_o high every cycle once primed.
- paddr=0: source 1 sends paddr=0, data=0x1234. Expect ready handshake completes, wb_en_o stays 0, and rr_q advances to 2.
- Backpressure: source 0 pushes 3 results with BUF_DEPTH=2 while sources 1–3 saturate. Expect src_ready_o[0]=0 after 2 pushes, the third held stable, and all 3 written in order with no loss or duplication.
- Flush: buffer 2 entries in source 3, assert flush_i. Expect no write for them and src_ready_o[3]=1 the next cycle.
- Async reset mid-stream: assert rst_i between clock edges while wb_en_o=1. Expect wb_en_o/addr/data/src go to 0 immediately and buffered entries are never written.
